// File: rtl/ram_pkg.sv
// Shared types for the dual-port RAM: cross-port read-during-write mode and
// the post-reset clear-sweep FSM state.
package ram_pkg;

    typedef enum {READ_FIRST, WRITE_FIRST} wr_mode_e;

    typedef enum logic {RAM_IDLE, RAM_CLEAR} ram_state_e;

endpackage

// File: rtl/ram_read_pipe.sv
// Read-data output stage for one RAM port: optional second register stage
// plus the matching valid pipeline. dout holds its value between reads.
module ram_read_pipe #(
    parameter int unsigned D          = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_en,
    input  logic [D-1:0] rd_data,
    output logic [D-1:0] dout,
    output logic         valid
);

    logic         stage_en;
    logic [D-1:0] stage_data;
    logic [D-1:0] dout_q;
    logic         valid_q;

    if (RD_LATENCY == 2) begin : g_two_stage
        logic [D-1:0] data1_q;
        logic         valid1_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data1_q  <= '0;
                valid1_q <= 1'b0;
            end else begin
                valid1_q <= rd_en;
                if (rd_en) begin
                    data1_q <= rd_data;
                end
            end
        end

        always_comb begin
            stage_en   = valid1_q;
            stage_data = data1_q;
        end
    end else begin : g_one_stage
        always_comb begin
            stage_en   = rd_en;
            stage_data = rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= stage_en;
            if (stage_en) begin
                dout_q <= stage_data;
            end
        end
    end

    always_comb begin
        dout  = dout_q;
        valid = valid_q;
    end

endmodule

// File: rtl/ram_dual_port.sv
// Dual-port synchronous RAM on one clock: CPU port A, video/DMA port B,
// configurable read latency, cross-port read-during-write mode, write collision
// detect and an optional post-reset clear sweep.
module ram_dual_port
  import ram_pkg::*;
#(
  parameter int unsigned   A              = 10,
  parameter int unsigned   D              = 8,
  parameter int unsigned   RD_LATENCY     = 1,
  parameter wr_mode_e      WR_MODE        = READ_FIRST,
  parameter string         INIT_FILE      = "ram.hex",
  parameter bit            CLEAR_ON_RESET = 1'b0,
  parameter logic [D-1:0]  CLEAR_VALUE    = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_cs,
  input  logic         a_rw,
  input  logic [A-1:0] a_addr,
  input  logic [D-1:0] a_di,
  output logic [D-1:0] a_dout,
  output logic         a_valid,
  input  logic         b_cs,
  input  logic         b_rw,
  input  logic [A-1:0] b_addr,
  input  logic [D-1:0] b_di,
  output logic [D-1:0] b_dout,
  output logic         b_valid,
  output logic         busy,
  output logic         collision
);

  localparam int unsigned  DEPTH       = 1 << A;
  localparam logic [A-1:0] LAST_ADDR   = '1;
  localparam ram_state_e   RESET_STATE = CLEAR_ON_RESET ? RAM_CLEAR : RAM_IDLE;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_dual_port: RD_LATENCY must be 1 or 2, got %0d", RD_LATENCY);
  end

  logic [D-1:0] mem [DEPTH];

  ram_state_e   state_q, state_d;
  logic [A-1:0] clr_cnt_q, clr_cnt_d;
  logic         collision_q, collision_d;

  logic         a_we, a_re, b_we_req, b_we, b_re;
  logic         same_addr;
  logic [D-1:0] a_rd_data, b_rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      collision_q <= collision_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    unique case (state_q)
      RAM_CLEAR: begin
        busy      = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = RAM_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Port A wins a same-address write clash; B's write is dropped.
  always_comb begin
    a_we        = a_cs & a_rw & ~busy;
    a_re        = a_cs & ~a_rw & ~busy;
    b_we_req    = b_cs & b_rw & ~busy;
    b_re        = b_cs & ~b_rw & ~busy;
    same_addr   = (a_addr == b_addr);
    collision_d = a_we & b_we_req & same_addr;
    b_we        = b_we_req & ~collision_d;
    collision   = collision_q;
  end

  always_comb begin
    a_rd_data = mem[a_addr];
    b_rd_data = mem[b_addr];
    if (WR_MODE == WRITE_FIRST) begin
      if (b_we && same_addr) begin
        a_rd_data = b_di;
      end
      if (a_we && same_addr) begin
        b_rd_data = a_di;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == RAM_CLEAR) begin
      mem[clr_cnt_q] <= CLEAR_VALUE;
    end else begin
      if (a_we) begin
        mem[a_addr] <= a_di;
      end
      if (b_we) begin
        mem[b_addr] <= b_di;
      end
    end
  end

  ram_read_pipe #(
    .D          (D),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (a_re),
    .rd_data (a_rd_data),
    .dout    (a_dout),
    .valid   (a_valid)
  );

  ram_read_pipe #(
    .D          (D),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (b_re),
    .rd_data (b_rd_data),
    .dout    (b_dout),
    .valid   (b_valid)
  );

endmodule

// File: tb/tb_ram_dual_port.sv
// Bench for ram_dual_port: two instances (latency 1 / READ_FIRST and
// latency 2 / WRITE_FIRST) share stimulus; read results go through a scoreboard.
module tb_ram_dual_port;
    import ram_pkg::*;

    typedef struct {
        int unsigned id;
        int unsigned due;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic       acs, arw;
        logic [3:0] aad;
        logic [7:0] adi;
        logic       bcs, brw;
        logic [3:0] bad;
        logic [7:0] bdi;
        logic [7:0] ea_rf, eb_rf, ea_wf, eb_wf;
        logic       coll;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_cs, a_rw, b_cs, b_rw;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_di, b_di;
    logic [7:0] a_dout1, b_dout1, a_dout2, b_dout2;
    logic       a_valid1, b_valid1, a_valid2, b_valid2;
    logic       busy1, busy2, coll1, coll2;

    int unsigned cyc    = 0;
    int unsigned passed = 0;
    int unsigned total  = 0;
    exp_t        sb[$];
    string       nm[6] = '{"u1.a", "u1.b", "u2.a", "u2.b", "u1.collision", "u2.collision"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ram_dual_port #(
        .A(4), .D(8), .RD_LATENCY(1), .WR_MODE(READ_FIRST), .INIT_FILE(""),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hE5)
    ) u1 (
        .clk(clk), .reset(reset),
        .a_cs(a_cs), .a_rw(a_rw), .a_addr(a_addr), .a_di(a_di), .a_dout(a_dout1), .a_valid(a_valid1),
        .b_cs(b_cs), .b_rw(b_rw), .b_addr(b_addr), .b_di(b_di), .b_dout(b_dout1), .b_valid(b_valid1),
        .busy(busy1), .collision(coll1)
    );

    ram_dual_port #(
        .A(4), .D(8), .RD_LATENCY(2), .WR_MODE(WRITE_FIRST), .INIT_FILE(""),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hE5)
    ) u2 (
        .clk(clk), .reset(reset),
        .a_cs(a_cs), .a_rw(a_rw), .a_addr(a_addr), .a_di(a_di), .a_dout(a_dout2), .a_valid(a_valid2),
        .b_cs(b_cs), .b_rw(b_rw), .b_addr(b_addr), .b_di(b_di), .b_dout(b_dout2), .b_valid(b_valid2),
        .busy(busy2), .collision(coll2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic expect_at(input int unsigned id, input int unsigned due, input logic [7:0] d);
        exp_t x;
        x.id   = id;
        x.due  = due;
        x.data = d;
        sb.push_back(x);
    endtask

    task automatic mon_port(input int unsigned id, input logic v, input logic [7:0] d);
        int idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].id == id) idx = i;
        if (v === 1'b1) begin
            total++;
            if (idx < 0) begin
                $display("FAIL %s: unexpected pulse at cycle %0d data %h, required no pulse", nm[id], cyc, d);
            end else begin
                if (sb[idx].due == cyc && d === sb[idx].data) passed++;
                else $display("FAIL %s: got data %h at cycle %0d, required %h at cycle %0d",
                              nm[id], d, cyc, sb[idx].data, sb[idx].due);
                sb.delete(idx);
            end
        end else if (idx >= 0 && sb[idx].due <= cyc) begin
            total++;
            $display("FAIL %s: no pulse at cycle %0d, required data %h", nm[id], cyc, sb[idx].data);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        mon_port(0, a_valid1, a_dout1);
        mon_port(1, b_valid1, b_dout1);
        mon_port(2, a_valid2, a_dout2);
        mon_port(3, b_valid2, b_dout2);
        mon_port(4, coll1, 8'h00);
        mon_port(5, coll2, 8'h00);
    end

    function automatic vec_t vec(input logic acs, input logic arw, input logic [3:0] aad,
                                 input logic [7:0] adi, input logic bcs, input logic brw,
                                 input logic [3:0] bad, input logic [7:0] bdi,
                                 input logic [7:0] ea_rf, input logic [7:0] eb_rf,
                                 input logic [7:0] ea_wf, input logic [7:0] eb_wf,
                                 input logic coll);
        vec_t v;
        v.acs = acs; v.arw = arw; v.aad = aad; v.adi = adi;
        v.bcs = bcs; v.brw = brw; v.bad = bad; v.bdi = bdi;
        v.ea_rf = ea_rf; v.eb_rf = eb_rf; v.ea_wf = ea_wf; v.eb_wf = eb_wf;
        v.coll = coll;
        return v;
    endfunction

    function automatic vec_t idle_v();
        return vec(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    endfunction

    task automatic set_idle();
        a_cs = 1'b0; a_rw = 1'b0; a_addr = 4'd0; a_di = 8'h00;
        b_cs = 1'b0; b_rw = 1'b0; b_addr = 4'd0; b_di = 8'h00;
    endtask

    // Drive one cycle of stimulus and log what each instance must return.
    task automatic step(input vec_t v, input bit live);
        int unsigned e;
        @(negedge clk);
        a_cs = v.acs; a_rw = v.arw; a_addr = v.aad; a_di = v.adi;
        b_cs = v.bcs; b_rw = v.brw; b_addr = v.bad; b_di = v.bdi;
        e = cyc + 1;
        if (live) begin
            if (v.acs && !v.arw) begin
                expect_at(0, e, v.ea_rf);
                expect_at(2, e + 1, v.ea_wf);
            end
            if (v.bcs && !v.brw) begin
                expect_at(1, e, v.eb_rf);
                expect_at(3, e + 1, v.eb_wf);
            end
            if (v.coll) begin
                expect_at(4, e, 8'h00);
                expect_at(5, e, 8'h00);
            end
        end
    endtask

    // Called right after reset release; counts cycles with busy high.
    task automatic count_busy(input bit poke, output int unsigned n1, output int unsigned n2);
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy1 && !busy2) break;
            if (busy1) n1++;
            if (busy2) n2++;
            if (poke) begin
                case (i)
                    10: begin
                        a_cs = 1'b1; a_rw = 1'b1; a_addr = 4'd2; a_di = 8'h77;
                        b_cs = 1'b1; b_rw = 1'b1; b_addr = 4'd2; b_di = 8'h66;
                    end
                    11: begin
                        a_cs = 1'b1; a_rw = 1'b0; a_addr = 4'd2;
                        b_cs = 1'b1; b_rw = 1'b0; b_addr = 4'd2;
                    end
                    12: set_idle();
                    default: ;
                endcase
            end
            @(negedge clk);
            #1;
        end
        set_idle();
    endtask

    task automatic read_all();
        for (int unsigned i = 0; i < 16; i++) begin
            step(vec(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 4'(15 - i), 8'h00,
                     8'hE5, 8'hE5, 8'hE5, 8'hE5, 1'b0), 1'b1);
        end
        repeat (3) step(idle_v(), 1'b0);
        chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[13];
        int unsigned n1, n2;

        tbl[0]  = vec(1'b1, 1'b1, 4'd3,  8'h5A, 1'b0, 1'b0, 4'd0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[1]  = vec(1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 4'd3,  8'h00, 8'h00, 8'h5A, 8'h00, 8'h5A, 1'b0);
        tbl[2]  = vec(1'b1, 1'b1, 4'd7,  8'h11, 1'b1, 1'b1, 4'd7,  8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tbl[3]  = vec(1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 1'b0, 4'd7,  8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 1'b0);
        tbl[4]  = vec(1'b1, 1'b1, 4'd5,  8'hAA, 1'b1, 1'b1, 4'd6,  8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[5]  = vec(1'b1, 1'b1, 4'd5,  8'hBB, 1'b1, 1'b0, 4'd5,  8'h00, 8'h00, 8'hAA, 8'h00, 8'hBB, 1'b0);
        tbl[6]  = vec(1'b1, 1'b0, 4'd6,  8'h00, 1'b1, 1'b0, 4'd5,  8'h00, 8'h66, 8'hBB, 8'h66, 8'hBB, 1'b0);
        tbl[7]  = vec(1'b1, 1'b0, 4'd9,  8'h00, 1'b1, 1'b1, 4'd9,  8'hC3, 8'hE5, 8'h00, 8'hC3, 8'h00, 1'b0);
        tbl[8]  = vec(1'b1, 1'b0, 4'd9,  8'h00, 1'b1, 1'b0, 4'd3,  8'h00, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 1'b0);
        tbl[9]  = vec(1'b1, 1'b0, 4'd10, 8'h00, 1'b1, 1'b0, 4'd7,  8'h00, 8'hE5, 8'h11, 8'hE5, 8'h11, 1'b0);
        tbl[10] = vec(1'b1, 1'b1, 4'd12, 8'h01, 1'b1, 1'b1, 4'd13, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[11] = vec(1'b1, 1'b0, 4'd13, 8'h00, 1'b1, 1'b0, 4'd12, 8'h00, 8'h02, 8'h01, 8'h02, 8'h01, 1'b0);
        tbl[12] = idle_v();

        reset = 1'b1;
        set_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_u1_a_dout", a_dout1, 8'h00);
        chk("rst_u1_b_dout", b_dout1, 8'h00);
        chk("rst_u1_a_valid", 8'(a_valid1), 8'h00);
        chk("rst_u1_b_valid", 8'(b_valid1), 8'h00);
        chk("rst_u1_collision", 8'(coll1), 8'h00);
        chk("rst_u2_a_dout", a_dout2, 8'h00);
        chk("rst_u2_b_dout", b_dout2, 8'h00);
        chk("rst_u2_a_valid", 8'(a_valid2), 8'h00);
        chk("rst_u2_b_valid", 8'(b_valid2), 8'h00);
        chk("rst_u2_collision", 8'(coll2), 8'h00);
        chk("rst_u1_busy", 8'(busy1), 8'h01);
        chk("rst_u2_busy", 8'(busy2), 8'h01);

        reset = 1'b0;
        count_busy(1'b1, n1, n2);
        chk("sweep1_busy_cycles_u1", 8'(n1), 8'd16);
        chk("sweep1_busy_cycles_u2", 8'(n2), 8'd16);
        read_all();

        for (int i = 0; i < 13; i++) step(tbl[i], 1'b1);
        repeat (3) step(idle_v(), 1'b0);
        chk("table_drained", 8'(sb.size()), 8'h00);
        chk("hold_u1_a_dout", a_dout1, 8'h02);
        chk("hold_u1_b_dout", b_dout1, 8'h01);
        chk("hold_u2_a_dout", a_dout2, 8'h02);
        chk("hold_u2_b_dout", b_dout2, 8'h01);

        // Reset asserted mid-cycle must clear outputs before the next edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_u1_a_dout", a_dout1, 8'h00);
        chk("async_u1_b_dout", b_dout1, 8'h00);
        chk("async_u2_a_dout", a_dout2, 8'h00);
        chk("async_u2_b_dout", b_dout2, 8'h00);
        chk("async_u1_busy", 8'(busy1), 8'h01);
        chk("async_u2_busy", 8'(busy2), 8'h01);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        repeat (8) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midsweep_u1_busy", 8'(busy1), 8'h01);
        chk("midsweep_u1_a_dout", a_dout1, 8'h00);
        chk("midsweep_u2_b_dout", b_dout2, 8'h00);
        @(negedge clk);
        #1 reset = 1'b0;
        count_busy(1'b0, n1, n2);
        chk("sweep2_busy_cycles_u1", 8'(n1), 8'd16);
        chk("sweep2_busy_cycles_u2", 8'(n2), 8'd16);
        read_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
